pe_serial_mc: RTL and testbench

PE_SERIAL_MC -- requirements
Module: pe_serial_mc

---
 rtl/pe_serial_mc_if.sv | 41 ++++
 rtl/pe_serial_mc.sv | 179 +++++++++++++++++
 tb/tb_pe_serial_mc.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_serial_mc_if.sv
// Operand, weight-write and result handshake bundle for pe_serial_mc.
// The master side drives operands and weights; the PE is the slave.
interface pe_serial_mc_if #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 24,
  parameter int NCH    = 4
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              w_we;
  logic [CW-1:0]     w_ch;
  logic [IWIDTH-1:0] w_data;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_ch;
  logic              sgn;
  logic              first;
  logic              last;
  logic [IWIDTH-1:0] ifm;
  logic [OWIDTH-1:0] sum_in;
  logic [IWIDTH-1:0] ifm_d;
  logic              ifm_valid_d;
  logic              out_valid;
  logic              out_ready;
  logic [OWIDTH-1:0] ofm;
  logic              sat_flag;

  modport master (
    output w_we, w_ch, w_data,
    output in_valid, in_ch, sgn, first, last, ifm, sum_in,
    output out_ready,
    input  in_ready, ifm_d, ifm_valid_d, out_valid, ofm, sat_flag
  );

  modport slave (
    input  w_we, w_ch, w_data,
    input  in_valid, in_ch, sgn, first, last, ifm, sum_in,
    input  out_ready,
    output in_ready, ifm_d, ifm_valid_d, out_valid, ofm, sat_flag
  );
endinterface

// File: rtl/pe_serial_mc.sv
// Bit-serial multiply-accumulate PE with a small per-channel weight store.
// One ifm bit per cycle builds the product, then one cycle accumulates it.
module pe_serial_mc #(
  parameter int IWIDTH = 8,
  parameter int OWIDTH = 24,
  parameter int NCH    = 4,
  parameter int SAT    = 0
) (
  input logic           clk,
  input logic           rst,
  pe_serial_mc_if.slave bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int KW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  localparam int PW = 2 * IWIDTH;
  localparam int XW = OWIDTH + 2;

  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

  state_t            state_q, state_d;
  logic [IWIDTH-1:0] w_q [NCH];
  logic [IWIDTH-1:0] w_d [NCH];
  logic [IWIDTH-1:0] x_q, x_d;
  logic [IWIDTH-1:0] wt_q, wt_d;
  logic              sgn_q, sgn_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic [KW-1:0]     k_q, k_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [OWIDTH-1:0] acc_q, acc_d;
  logic [OWIDTH-1:0] ofm_q, ofm_d;
  logic [IWIDTH-1:0] fwd_q, fwd_d;
  logic              fwd_v_q, fwd_v_d;
  logic              ov_q, ov_d;
  logic              sat_q, sat_d;

  logic [PW-1:0]     wext;
  logic [XW-1:0]     pext;
  logic [XW-1:0]     base;
  logic [XW-1:0]     sum;
  logic [2:0]        top;
  logic              ovf;
  logic [OWIDTH-1:0] clamp;

  always_comb begin
    wext  = sgn_q ? {{IWIDTH{wt_q[IWIDTH-1]}}, wt_q}
                  : {{IWIDTH{1'b0}}, wt_q};
    pext  = sgn_q ? {{(XW-PW){prod_q[PW-1]}}, prod_q}
                  : {{(XW-PW){1'b0}}, prod_q};
    base  = first_q ? {{2{bus.sum_in[OWIDTH-1]}}, bus.sum_in}
                    : {{2{acc_q[OWIDTH-1]}}, acc_q};
    sum   = base + pext;
    // Result fits iff the two guard bits match the OWIDTH sign bit.
    top   = sum[XW-1:OWIDTH-1];
    ovf   = !((&top) || !(|top));
    clamp = sum[XW-1] ? {1'b1, {(OWIDTH-1){1'b0}}}
                      : {1'b0, {(OWIDTH-1){1'b1}}};
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    x_d     = x_q;
    wt_d    = wt_q;
    sgn_d   = sgn_q;
    first_d = first_q;
    last_d  = last_q;
    k_d     = k_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    ofm_d   = ofm_q;
    fwd_d   = fwd_q;
    fwd_v_d = 1'b0;
    ov_d    = ov_q;
    sat_d   = sat_q;

    if (bus.w_we && (32'(bus.w_ch) < NCH))
      w_d[bus.w_ch] = bus.w_data;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.ifm;
          sgn_d   = bus.sgn;
          first_d = bus.first;
          last_d  = bus.last;
          // Reads the pre-write value when a write hits the same channel.
          wt_d    = (32'(bus.in_ch) < NCH) ? w_q[bus.in_ch] : '0;
          k_d     = '0;
          prod_d  = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (k_q == '0) begin
          fwd_d   = x_q;
          fwd_v_d = 1'b1;
        end
        if (x_q[k_q]) begin
          if (sgn_q && (k_q == KW'(IWIDTH - 1)))
            prod_d = prod_q - (wext << k_q);
          else
            prod_d = prod_q + (wext << k_q);
        end
        k_d = k_q + 1'b1;
        if (k_q == KW'(IWIDTH - 1))
          state_d = ACC;
      end
      ACC: begin
        if ((SAT != 0) && ovf) begin
          acc_d = clamp;
          sat_d = 1'b1;
        end else begin
          acc_d = sum[OWIDTH-1:0];
          if (first_q)
            sat_d = 1'b0;
        end
        if (last_q) begin
          ofm_d   = acc_d;
          ov_d    = 1'b1;
          state_d = OUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NCH; i++)
        w_q[i] <= '0;
      x_q     <= '0;
      wt_q    <= '0;
      sgn_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      k_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      ofm_q   <= '0;
      fwd_q   <= '0;
      fwd_v_q <= 1'b0;
      ov_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      x_q     <= x_d;
      wt_q    <= wt_d;
      sgn_q   <= sgn_d;
      first_q <= first_d;
      last_q  <= last_d;
      k_q     <= k_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      ofm_q   <= ofm_d;
      fwd_q   <= fwd_d;
      fwd_v_q <= fwd_v_d;
      ov_q    <= ov_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.ifm_d       = fwd_q;
  assign bus.ifm_valid_d = fwd_v_q;
  assign bus.out_valid   = ov_q;
  assign bus.ofm         = ofm_q;
  assign bus.sat_flag    = sat_q;
endmodule

// File: tb/tb_pe_serial_mc.sv
// Drives a wrapping 24-bit PE and a saturating 16-bit PE in lockstep
// against an arithmetic reference model.
module tb_pe_serial_mc;
  localparam int IW  = 8;
  localparam int NCH = 4;

  logic clk;
  logic rst;
  logic       w_we;
  logic [1:0] w_ch;
  logic [7:0] w_data;
  logic       in_valid;
  logic [1:0] in_ch;
  logic       sgn, first, last;
  logic [7:0] ifm;
  int         sin;
  logic       out_ready;

  int n_cmp;
  int n_err;

  logic [7:0] mw [NCH];
  longint acc0, acc1, ofm0, ofm1;
  logic   sat1;

  pe_serial_mc_if #(.IWIDTH(IW), .OWIDTH(24), .NCH(NCH)) bus0 ();
  pe_serial_mc_if #(.IWIDTH(IW), .OWIDTH(16), .NCH(NCH)) bus1 ();

  pe_serial_mc #(.IWIDTH(IW), .OWIDTH(24), .NCH(NCH), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  pe_serial_mc #(.IWIDTH(IW), .OWIDTH(16), .NCH(NCH), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  assign bus0.w_we      = w_we;
  assign bus0.w_ch      = w_ch;
  assign bus0.w_data    = w_data;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_ch     = in_ch;
  assign bus0.sgn       = sgn;
  assign bus0.first     = first;
  assign bus0.last      = last;
  assign bus0.ifm       = ifm;
  assign bus0.sum_in    = 24'(sin);
  assign bus0.out_ready = out_ready;
  assign bus1.w_we      = w_we;
  assign bus1.w_ch      = w_ch;
  assign bus1.w_data    = w_data;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_ch     = in_ch;
  assign bus1.sgn       = sgn;
  assign bus1.first     = first;
  assign bus1.last      = last;
  assign bus1.ifm       = ifm;
  assign bus1.sum_in    = 16'(sin);
  assign bus1.out_ready = out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap24(input longint r);
    longint v;
    v = r & 64'hFF_FFFF;
    if (v >= 64'sh80_0000) v = v - 64'sh100_0000;
    return v;
  endfunction

  function automatic longint s24(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint s16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mw[i] = '0;
    acc0 = 0; acc1 = 0; ofm0 = 0; ofm1 = 0; sat1 = 1'b0;
  endtask

  task automatic write_w(input int ch, input logic [7:0] v);
    w_we = 1'b1; w_ch = 2'(ch); w_data = v;
    @(posedge clk); #1;
    w_we = 1'b0;
    mw[ch] = v;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int cnt;
    cnt = 0;
    while (!(bus0.in_ready && bus1.in_ready) && cnt < 50) begin
      @(negedge clk); cnt++;
    end
    chk("in_ready_wait", longint'(bus0.in_ready && bus1.in_ready), 1);
  endtask

  task automatic op(input int ch, input logic [7:0] x, input logic s,
                    input logic f, input logic l, input int si,
                    input int hold, input logic cw, input logic [7:0] cwv);
    longint wv, xv, p, r0, r1;
    longint h0, h1;
    wait_ready();
    in_valid = 1'b1; in_ch = 2'(ch); ifm = x; sgn = s;
    first = f; last = l; sin = si;
    if (cw) begin
      w_we = 1'b1; w_ch = 2'(ch); w_data = cwv;
    end
    wv = s ? longint'($signed(mw[ch])) : longint'(mw[ch]);
    xv = s ? longint'($signed(x)) : longint'(x);
    p  = wv * xv;
    if (cw) mw[ch] = cwv;
    @(posedge clk); #1;
    in_valid = 1'b0; w_we = 1'b0;
    @(negedge clk);
    chk("busy_in_ready", longint'(bus0.in_ready), 0);
    chk("pulse_early", longint'(bus0.ifm_valid_d), 0);
    @(negedge clk);
    chk("pulse", longint'({bus0.ifm_valid_d, bus1.ifm_valid_d}), 3);
    chk("ifm_d", longint'(bus0.ifm_d), longint'(x));
    repeat (IW - 1) @(negedge clk);
    chk("out_valid_early", longint'(bus0.out_valid | bus1.out_valid), 0);
    @(negedge clk);
    r0 = (f ? longint'(si) : acc0) + p;
    acc0 = wrap24(r0);
    r1 = (f ? longint'(si) : acc1) + p;
    if (r1 > 32767) begin
      acc1 = 32767; sat1 = 1'b1;
    end else if (r1 < -32768) begin
      acc1 = -32768; sat1 = 1'b1;
    end else begin
      acc1 = r1;
      if (f) sat1 = 1'b0;
    end
    if (l) begin
      ofm0 = acc0; ofm1 = acc1;
    end
    chk("out_valid0", longint'(bus0.out_valid), longint'(l));
    chk("out_valid1", longint'(bus1.out_valid), longint'(l));
    chk("ofm_wrap", s24(bus0.ofm), ofm0);
    chk("ofm_sat", s16(bus1.ofm), ofm1);
    chk("sat_flag0", longint'(bus0.sat_flag), 0);
    chk("sat_flag1", longint'(bus1.sat_flag), longint'(sat1));
    if (l) begin
      h0 = s24(bus0.ofm); h1 = s16(bus1.ofm);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", longint'(bus0.out_valid && bus1.out_valid), 1);
        chk("hold_ofm0", s24(bus0.ofm), h0);
        chk("hold_ofm1", s16(bus1.ofm), h1);
        chk("hold_in_ready", longint'(bus0.in_ready | bus1.in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drop_valid", longint'(bus0.out_valid | bus1.out_valid), 0);
      chk("ready_after", longint'(bus0.in_ready && bus1.in_ready), 1);
      chk("ofm_kept", s24(bus0.ofm), ofm0);
    end else begin
      chk("ready_next", longint'(bus0.in_ready && bus1.in_ready), 1);
    end
  endtask

  task automatic mid_reset();
    int seen;
    wait_ready();
    in_valid = 1'b1; in_ch = 2'd1; ifm = 8'h5A; sgn = 1'b0;
    first = 1'b1; last = 1'b1; sin = 1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ofm0", s24(bus0.ofm), 0);
    chk("rst_ofm1", s16(bus1.ofm), 0);
    chk("rst_ifm_d", longint'(bus0.ifm_d), 0);
    chk("rst_pulse", longint'(bus0.ifm_valid_d), 0);
    chk("rst_valid", longint'(bus0.out_valid | bus1.out_valid), 0);
    chk("rst_sat", longint'(bus1.sat_flag), 0);
    chk("rst_in_ready", longint'(bus0.in_ready && bus1.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 0;
    repeat (IW + 4) begin
      @(negedge clk);
      if (bus0.out_valid || bus1.out_valid) seen++;
    end
    chk("no_valid_after_rst", longint'(seen), 0);
    chk("ofm_after_rst", s24(bus0.ofm), 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; w_we = 1'b0; w_ch = '0; w_data = '0;
    in_valid = 1'b0; in_ch = '0; sgn = 1'b0; first = 1'b0;
    last = 1'b0; ifm = '0; sin = 0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_in_ready", longint'(bus0.in_ready && bus1.in_ready), 1);
    chk("reset_ofm", s24(bus0.ofm), 0);
    chk("reset_valid", longint'(bus0.out_valid | bus1.out_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    write_w(2, 8'hFD);
    op(2, 8'd5, 1'b1, 1'b1, 1'b1, 100, 0, 1'b0, 8'd0);
    write_w(1, 8'd255);
    op(1, 8'd255, 1'b0, 1'b1, 1'b1, 0, 1, 1'b0, 8'd0);
    write_w(1, 8'h80);
    op(1, 8'h80, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 8'd0);
    write_w(3, 8'd1);
    op(3, 8'd1, 1'b0, 1'b1, 1'b1, 32767, 0, 1'b0, 8'd0);
    op(3, 8'd1, 1'b0, 1'b1, 1'b1, 5, 0, 1'b0, 8'd0);
    write_w(0, 8'd2);
    op(0, 8'd1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 8'd0);
    op(0, 8'd2, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 8'd0);
    op(0, 8'd3, 1'b0, 1'b0, 1'b1, 0, 5, 1'b0, 8'd0);
    write_w(0, 8'd4);
    op(0, 8'd1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 8'd7);
    op(0, 8'd1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 8'd0);

    mid_reset();

    for (int i = 0; i < NCH; i++)
      write_w(i, 8'($urandom));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        write_w(int'($urandom_range(0, NCH - 1)), 8'($urandom));
      op(int'($urandom_range(0, NCH - 1)), 8'($urandom),
         1'($urandom), 1'($urandom_range(0, 2) == 0),
         1'($urandom_range(0, 2) == 0),
         int'($urandom_range(0, 65535)) - 32768,
         int'($urandom_range(0, 3)),
         1'($urandom_range(0, 5) == 0), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
